// File: rtl/sm_mem_2rw_arb.sv
// Round-robin arbiter sharing a dual-port SRAM among p_nreq requesters; up to two grants per cycle (A then B).
// Grant/req_rdy is combinational, read data returns one cycle after grant; no response backpressure.
module sm_mem_2rw_arb #(
  parameter  int p_wid   = 64,
  parameter  int p_dep   = 64,
  parameter  int p_nreq  = 4,
  localparam int lp_awid = $clog2(p_dep),
  localparam int lp_iwid = $clog2(p_nreq)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [p_nreq-1:0]          req_val,
  output logic [p_nreq-1:0]          req_rdy,
  input  logic [p_nreq-1:0]          req_wen,
  input  logic [p_nreq*lp_awid-1:0]  req_addr,
  input  logic [p_nreq*p_wid-1:0]    req_wdata,
  output logic [p_nreq-1:0]          resp_val,
  output logic [p_nreq*p_wid-1:0]    resp_rdata,
  output logic                       mem_cenA,
  output logic                       mem_cenB,
  output logic                       mem_rwenA,
  output logic                       mem_rwenB,
  output logic [lp_awid-1:0]         mem_aA,
  output logic [lp_awid-1:0]         mem_aB,
  output logic [p_wid-1:0]           mem_dA,
  output logic [p_wid-1:0]           mem_dB,
  input  logic [p_wid-1:0]           mem_qA,
  input  logic [p_wid-1:0]           mem_qB
);

  logic [lp_iwid-1:0] rr_q, rr_d;
  logic               tag_a_val_q, tag_a_val_d, tag_b_val_q, tag_b_val_d;
  logic [lp_iwid-1:0] tag_a_id_q, tag_a_id_d, tag_b_id_q, tag_b_id_d;

  logic [lp_awid-1:0] addr [p_nreq];
  logic [p_wid-1:0]   wdat [p_nreq];
  logic               ga_vld, gb_vld;
  logic [lp_iwid-1:0] ga_id, gb_id, cand;
  int                 idx;

  function automatic logic [lp_iwid-1:0] inc_mod(input logic [lp_iwid-1:0] i);
    return (int'(i) == p_nreq - 1) ? '0 : i + lp_iwid'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < p_nreq; i++) begin
      addr[i] = req_addr[i*lp_awid +: lp_awid];
      wdat[i] = req_wdata[i*p_wid +: p_wid];
    end
  end

  // Scan from rr_q; B skips anything that collides with A's address unless both are reads.
  always_comb begin
    ga_vld = 1'b0;
    gb_vld = 1'b0;
    ga_id  = '0;
    gb_id  = '0;
    cand   = '0;
    idx    = 0;
    for (int k = 0; k < p_nreq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= p_nreq) idx = idx - p_nreq;
      cand = lp_iwid'(idx);
      if (req_val[cand]) begin
        if (!ga_vld) begin
          ga_vld = 1'b1;
          ga_id  = cand;
        end else if (!gb_vld &&
                     !((addr[cand] == addr[ga_id]) && (req_wen[cand] || req_wen[ga_id]))) begin
          gb_vld = 1'b1;
          gb_id  = cand;
        end
      end
    end
  end

  always_comb begin
    req_rdy   = '0;
    mem_cenA  = 1'b1;
    mem_rwenA = 1'b1;
    mem_aA    = '0;
    mem_dA    = '0;
    mem_cenB  = 1'b1;
    mem_rwenB = 1'b1;
    mem_aB    = '0;
    mem_dB    = '0;
    if (!rst && ga_vld) begin
      req_rdy[ga_id] = 1'b1;
      mem_cenA       = 1'b0;
      mem_rwenA      = ~req_wen[ga_id];
      mem_aA         = addr[ga_id];
      mem_dA         = wdat[ga_id];
    end
    if (!rst && gb_vld) begin
      req_rdy[gb_id] = 1'b1;
      mem_cenB       = 1'b0;
      mem_rwenB      = ~req_wen[gb_id];
      mem_aB         = addr[gb_id];
      mem_dB         = wdat[gb_id];
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gb_vld)      rr_d = inc_mod(gb_id);
    else if (ga_vld) rr_d = inc_mod(ga_id);
    tag_a_val_d = ga_vld && !req_wen[ga_id];
    tag_a_id_d  = ga_id;
    tag_b_val_d = gb_vld && !req_wen[gb_id];
    tag_b_id_d  = gb_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      tag_a_val_q <= 1'b0;
      tag_a_id_q  <= '0;
      tag_b_val_q <= 1'b0;
      tag_b_id_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      tag_a_val_q <= tag_a_val_d;
      tag_a_id_q  <= tag_a_id_d;
      tag_b_val_q <= tag_b_val_d;
      tag_b_id_q  <= tag_b_id_d;
    end
  end

  // Data lanes are don't-care unless resp_val is set, so no per-requester hold registers.
  always_comb begin
    resp_val = '0;
    for (int i = 0; i < p_nreq; i++) begin
      resp_rdata[i*p_wid +: p_wid] =
        (tag_b_val_q && (tag_b_id_q == lp_iwid'(i))) ? mem_qB : mem_qA;
    end
    if (tag_a_val_q) resp_val[tag_a_id_q] = 1'b1;
    if (tag_b_val_q) resp_val[tag_b_id_q] = 1'b1;
  end

endmodule
